// File: rtl/cpu_step_ctrl.sv
// Run/single-step sequencer: turns free-run, debounced step and halt
// into a one-cycle cpu_en strobe, and holds ready for one CPU step.
module cpu_step_ctrl #(
  parameter int DIV_W = 25,
  parameter int DB_W  = 20,
  parameter int CNT_W = 16
) (
  input  logic             fastclk,
  input  logic             n_reset,
  input  logic             run_sw,
  input  logic [1:0]       rate_sel,
  input  logic             step_btn,
  input  logic             ready_btn,
  input  logic             halt_in,
  output logic             cpu_en,
  output logic             ready_out,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] step_count
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    STEP    = 3'd2,
    RELEASE = 3'd3,
    HALT    = 3'd4
  } state_t;

  state_t state_q;
  state_t state_next;
  logic   en_next;

  logic       run_m;
  logic       run_s;
  logic [1:0] rate_m;
  logic [1:0] rate_s;

  // Index 0 is the step button, index 1 the ready button.
  logic [1:0]           btn_raw;
  logic [1:0]           btn_m;
  logic [1:0]           btn_s;
  logic [1:0]           db_stable;
  logic [1:0]           db_stable_d;
  logic [1:0]           db_rise;
  logic [1:0][DB_W-1:0] db_cnt;

  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_mask;
  logic             div_term;
  int unsigned      div_bits;

  assign btn_raw = {ready_btn, step_btn};
  assign state   = state_q;

  always_ff @(posedge fastclk) begin
    if (!n_reset) begin
      run_m       <= 1'b0;
      run_s       <= 1'b0;
      rate_m      <= '0;
      rate_s      <= '0;
      btn_m       <= '0;
      btn_s       <= '0;
      db_stable   <= '0;
      db_stable_d <= '0;
      db_rise     <= '0;
      db_cnt      <= '0;
    end else begin
      run_m       <= run_sw;
      run_s       <= run_m;
      rate_m      <= rate_sel;
      rate_s      <= rate_m;
      btn_m       <= btn_raw;
      btn_s       <= btn_m;
      db_stable_d <= db_stable;
      db_rise     <= db_stable & ~db_stable_d;
      for (int i = 0; i < 2; i++) begin
        if (btn_s[i] == db_stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == '1) begin
          db_stable[i] <= ~db_stable[i];
          db_cnt[i]    <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Terminal on the low (DIV_W - 4*rate) bits, so a rate change
  // only ever shortens the mask to another legitimate terminal.
  always_comb begin
    div_bits = DIV_W - 4 * int'(rate_s);
    div_mask = ~({DIV_W{1'b1}} << div_bits);
    div_term = (div_cnt & div_mask) == div_mask;
  end

  always_ff @(posedge fastclk) begin
    if (!n_reset) begin
      div_cnt <= '0;
    end else if (state_q != RUN && state_next == RUN) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  always_comb begin
    state_next = state_q;
    en_next    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (run_s) begin
          state_next = RUN;
        end else if (db_rise[0]) begin
          state_next = STEP;
          en_next    = 1'b1;
        end
      end
      RUN: begin
        if (!run_s) begin
          state_next = IDLE;
        end else if (halt_in) begin
          state_next = HALT;
        end else begin
          en_next = div_term;
        end
      end
      STEP: begin
        state_next = RELEASE;
      end
      RELEASE: begin
        if (!db_stable[0]) begin
          state_next = IDLE;
        end
      end
      HALT: begin
        if (!run_s) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge fastclk) begin
    if (!n_reset) begin
      state_q <= IDLE;
      cpu_en  <= 1'b0;
    end else begin
      state_q <= state_next;
      cpu_en  <= en_next;
    end
  end

  // A ready press on the clearing strobe is kept for the next step.
  always_ff @(posedge fastclk) begin
    if (!n_reset) begin
      ready_out  <= 1'b0;
      step_count <= '0;
    end else begin
      if (db_rise[1] && state_q != HALT) begin
        ready_out <= 1'b1;
      end else if (cpu_en) begin
        ready_out <= 1'b0;
      end
      if (cpu_en) begin
        step_count <= step_count + 1'b1;
      end
    end
  end

endmodule

// File: doc/cpu_step_ctrl.md
Name: cpu_step_ctrl

Overview:
Run/single-step sequencer for the CPU core, clocked from the 50 MHz board clock.
- Replaces a free-running divided clock with a one-cycle clock-enable strobe (cpu_en). The CPU core runs on fastclk gated by cpu_en.
- Supports free-run at a switch-selectable rate, debounced single-step from a push-button, and CPU-requested halt.
- Also debounces the operator "ready" button and holds the CPU ready input high for exactly one CPU step.

Parameters:
- DIV_W, 25: free-run base divider width. Period is 2^(DIV_W-4*rate_sel) fastclk cycles. DIV_W must be >= 13.
- DB_W, 20: debounce counter width. Stability window is 2^DB_W cycles, about 21 ms at 50 MHz.
- CNT_W, 16: width of step_count.

Ports:
- fastclk, input, 1: sole clock, 50 MHz.
- n_reset, input, 1: synchronous, active-low reset.
- run_sw, input, 1: 1 = free-run requested. Asynchronous; 2-FF synchronised, not debounced.
- rate_sel, input, 2: free-run rate select. Asynchronous; 2-FF synchronised.
- step_btn, input, 1: raw single-step push-button, active high.
- ready_btn, input, 1: raw ready push-button, active high.
- halt_in, input, 1: CPU halt request. Synchronous to fastclk; level.
- cpu_en, output, 1: one-fastclk-cycle CPU advance strobe.
- ready_out, output, 1: to CPU ready_in.
- state, output, 3: current FSM state encoding, for LEDs.
- step_count, output, CNT_W: number of cpu_en pulses issued. Wraps.

Behaviour:

Reset (n_reset=0 at a rising edge):
- state=IDLE, cpu_en=0, ready_out=0, step_count=0.
- Divider, debounce counters, synchronisers and stable levels all cleared to 0.
- Reset mid-operation aborts any pulse or wait. No pulse is issued on the edge where reset is sampled.

Debouncers (identical logic for step_btn and ready_btn):
- Input passes through a 2-FF synchroniser to give "synced".
- While synced != stable, the counter increments each cycle. While synced == stable, the counter clears.
- On the cycle the counter equals 2^DB_W-1 and synced != stable: stable flips and the counter clears.
- A glitch shorter than 2^DB_W cycles produces no change in stable.
- A rise event is a 1-cycle pulse registered the cycle after stable goes 0 to 1.

Divider:
- Free-running counter, cleared on entry to RUN.
- Terminal when its low (DIV_W-4*rate_sel) bits are all ones.
- A rate_sel change mid-run takes effect immediately; no glitch pulse is allowed beyond the normal terminal condition.

FSM states and encoding: IDLE=0, RUN=1, STEP=2, RELEASE=3, HALT=4.
- IDLE: run_sw=1 goes to RUN. Otherwise a step rise event goes to STEP. If both occur in the same cycle, RUN wins and the step event is discarded.
- RUN:
  - halt_in=1 goes to HALT with no pulse, even if the divider is terminal.
  - Otherwise run_sw=0 goes to IDLE. If halt_in=1 and run_sw=0 together, go to IDLE.
  - Otherwise cpu_en=1 on each divider terminal cycle.
- STEP: cpu_en=1 for exactly this one cycle, then go to RELEASE.
- RELEASE: wait until step stable=0, then go to IDLE. Further presses are ignored until release.
- HALT: no pulses; step and ready events are ignored. run_sw=0 goes to IDLE.
- cpu_en is registered, asserted in the cycle the FSM is in STEP or on a RUN terminal cycle. It is never high on two consecutive cycles, except in RUN when the period is 1 (not reachable with DIV_W >= 13).

step_count:
- Increments by 1 on every cycle with cpu_en=1.
- Wraps from 2^CNT_W-1 to 0.

ready_out:
- Set on a ready rise event.
- Cleared on the cycle after the first cpu_en that occurs while ready_out=1. The CPU therefore samples ready=1 on exactly one step.
- A ready event arriving on the same cycle as that clearing cpu_en keeps ready_out=1 for the next step; set has priority.

Latency:
- step_btn rises and is held from edge N: stable flips at edge N+2+2^DB_W, the rise event follows at the next edge, and cpu_en is high one edge after that.
- Total latency is 2^DB_W+4 edges.

Test Plan:
1. Reset then idle. Hold n_reset=0 for 3 cycles, then release with all inputs 0 for 100 cycles. Required: cpu_en=0, ready_out=0, state=0 and step_count=0 throughout.
2. Single step, debounce filter (DB_W=4). Pulse step_btn high for 10 cycles: no cpu_en. Then hold high for 40 cycles: exactly one cpu_en, at 20 edges after the rise, with step_count=1 and state going 2, then 3. Release and hold low: state returns to 0 after about 18 cycles.
3. Free-run rate (DIV_W=13). run_sw=1, rate_sel=2: cpu_en every 32 cycles, 10 pulses in 320 cycles. Switch to rate_sel=3: a pulse every 2 cycles. Set run_sw=0: pulses stop and state=0.
4. Halt priority. In RUN, assert halt_in on a divider-terminal cycle: no cpu_en, state=4. A step press then issues no pulse. run_sw=0 gives state=0.
5. Ready hold. Press ready_btn (debounced) while in IDLE: ready_out=1. It stays 1 until one step issues cpu_en, then drops to 0 on the next cycle. step_count increments by 1.
6. Wrap and reset mid-op (CNT_W=4). Issue 17 pulses: step_count=1. Assert n_reset during RELEASE: state=0 and step_count=0 on the next edge, with no stray cpu_en.
